// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle: NREQ requesters offering (addr, data) writes to the register file.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;

  modport master (output req_valid, output req_addr, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_addr, input  req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file write port, with a registered write stage
// and a pending-write scoreboard that flags read-after-write hazards on both read ports.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  req,
  output logic                 rf_rw,
  output logic [AW-1:0]        rf_addr3,
  output logic [DW-1:0]        rf_wdata,
  input  logic                 pend_set,
  input  logic [AW-1:0]        pend_addr,
  input  logic [AW-1:0]        rd_addr1,
  input  logic [AW-1:0]        rd_addr2,
  output logic                 hazard1,
  output logic                 hazard2,
  output logic [(2**AW)-1:0]   busy_mask,
  output logic                 dup_err
);

  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREG = 2**AW;
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  logic [AW-1:0]   addr_a [NREQ];
  logic [DW-1:0]   data_a [NREQ];

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rf_rw_q, rf_rw_d;
  logic [AW-1:0]   rf_addr3_q, rf_addr3_d;
  logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            dup_err_q, dup_err_d;

  logic [NREQ-1:0] gnt_c;
  logic [PW-1:0]   gnt_idx_c;
  logic            found_c;
  logic            clr_hit_c;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = req.req_addr[i*AW +: AW];
    assign data_a[i] = req.req_data[i*DW +: DW];
  end

  // Search starts just after the last winner, so the previous winner has lowest priority.
  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    found_c   = 1'b0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (!found_c && req.req_valid[PW'((int'(ptr_q) + k) % int'(NREQ))]) begin
        found_c   = 1'b1;
        gnt_idx_c = PW'((int'(ptr_q) + k) % int'(NREQ));
      end
    end
    if (found_c) gnt_c[gnt_idx_c] = 1'b1;
  end

  assign req.req_ready = gnt_c;

  // Write stage: a handshake to x0 still advances the pointer but never raises rf_rw.
  always_comb begin
    ptr_d      = ptr_q;
    rf_rw_d    = 1'b0;
    rf_addr3_d = rf_addr3_q;
    rf_wdata_d = rf_wdata_q;
    if (found_c) begin
      ptr_d      = gnt_idx_c;
      rf_rw_d    = (addr_a[gnt_idx_c] != '0);
      rf_addr3_d = addr_a[gnt_idx_c];
      rf_wdata_d = data_a[gnt_idx_c];
    end
  end

  // Scoreboard: clear on commit, then set, so a same-edge set wins over the clear.
  always_comb begin
    busy_d    = busy_q;
    dup_err_d = dup_err_q;
    clr_hit_c = rf_rw_q && (rf_addr3_q == pend_addr);
    if (rf_rw_q) busy_d[rf_addr3_q] = 1'b0;
    if (pend_set && (pend_addr != '0)) begin
      if (busy_q[pend_addr] && !clr_hit_c) dup_err_d = 1'b1;
      busy_d[pend_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= PTR_RST;
      rf_rw_q    <= 1'b0;
      rf_addr3_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
      dup_err_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      rf_rw_q    <= rf_rw_d;
      rf_addr3_q <= rf_addr3_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
      dup_err_q  <= dup_err_d;
    end
  end

  assign rf_rw     = rf_rw_q;
  assign rf_addr3  = rf_addr3_q;
  assign rf_wdata  = rf_wdata_q;
  assign busy_mask = busy_q;
  assign dup_err   = dup_err_q;
  assign hazard1   = busy_q[rd_addr1];
  assign hazard2   = busy_q[rd_addr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic        clk;
  logic        rst_n;
  logic        rf_rw;
  logic [4:0]  rf_addr3;
  logic [31:0] rf_wdata;
  logic        pend_set;
  logic [4:0]  pend_addr, rd_addr1, rd_addr2;
  logic        hazard1, hazard2;
  logic [31:0] busy_mask;
  logic        dup_err;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) wb ();

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(wb),
    .rf_rw(rf_rw), .rf_addr3(rf_addr3), .rf_wdata(rf_wdata),
    .pend_set(pend_set), .pend_addr(pend_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .hazard1(hazard1), .hazard2(hazard2),
    .busy_mask(busy_mask), .dup_err(dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Requester-side stimulus
  logic [2:0]  rv;
  logic [4:0]  ra [NREQ];
  logic [31:0] rd [NREQ];

  // Reference model state
  bit          m_rw;
  bit [4:0]    m_addr;
  bit [31:0]   m_data;
  bit [31:0]   m_busy;
  bit          m_dup;
  int          m_last;
  int          last_g;

  logic [2:0]  rot [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    wb.req_valid = rv;
    for (int i = 0; i < NREQ; i++) begin
      wb.req_addr[i*AW +: AW] = ra[i];
      wb.req_data[i*DW +: DW] = rd[i];
    end
  endtask

  task automatic model_reset();
    m_rw = 0; m_addr = 0; m_data = 0; m_busy = 0; m_dup = 0;
    m_last = NREQ - 1; last_g = -1;
  endtask

  function automatic int model_grant();
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (m_last + k) % NREQ;
      if (rv[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int g;
    bit [31:0] nb;
    g  = model_grant();
    nb = m_busy;
    if (m_rw) nb[m_addr] = 1'b0;
    if (pend_set && pend_addr != 0) begin
      if (m_busy[pend_addr] && !(m_rw && m_addr == pend_addr)) m_dup = 1'b1;
      nb[pend_addr] = 1'b1;
    end
    nb[0]  = 1'b0;
    m_busy = nb;
    last_g = g;
    if (g >= 0) begin
      m_last = g;
      m_rw   = (ra[g] != 0);
      m_addr = ra[g];
      m_data = rd[g];
    end else begin
      m_rw = 1'b0;
    end
  endtask

  // One clock: combinational checks at negedge, model update at posedge, registered checks after.
  task automatic cyc();
    int g;
    logic [2:0] er;
    @(negedge clk);
    g  = model_grant();
    er = (g >= 0) ? 3'(1 << g) : 3'b000;
    check("req_ready", 64'(wb.req_ready), 64'(er));
    check("hazard1", 64'(hazard1), 64'(m_busy[rd_addr1]));
    check("hazard2", 64'(hazard2), 64'(m_busy[rd_addr2]));
    @(posedge clk);
    model_edge();
    #1;
    check("rf_rw", 64'(rf_rw), 64'(m_rw));
    check("busy_mask", 64'(busy_mask), 64'(m_busy));
    check("dup_err", 64'(dup_err), 64'(m_dup));
    if (m_rw) begin
      check("rf_addr3", 64'(rf_addr3), 64'(m_addr));
      check("rf_wdata", 64'(rf_wdata), 64'(m_data));
    end
  endtask

  initial begin
    rst_n = 1'b0; rv = '0; pend_set = 0; pend_addr = 0; rd_addr1 = 0; rd_addr2 = 0;
    for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rd[i] = '0; end
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rf_rw", 64'(rf_rw), 64'd0);
    check("rst_busy", 64'(busy_mask), 64'd0);
    check("rst_dup", 64'(dup_err), 64'd0);
    check("rst_addr3", 64'(rf_addr3), 64'd0);
    check("rst_wdata", 64'(rf_wdata), 64'd0);
    rst_n = 1'b1;

    // Rotation with all three requesters valid; r9 marked pending along the way
    rv = 3'b111; ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd3;
    pend_set = 1; pend_addr = 5'd9;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++) rd[i] = $urandom;
      drive();
      #1;
      check("rot_ready", 64'(wb.req_ready), 64'(rot[c]));
      cyc();
      check("rot_rw", 64'(rf_rw), 64'd1);
      pend_set = 0;
    end

    // Reset mid-stream with a write in flight and r9 busy
    check("pre_rst_busy9", 64'(busy_mask[9]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rw", 64'(rf_rw), 64'd0);
    check("mid_rst_busy", 64'(busy_mask), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_rw", 64'(rf_rw), 64'd0);
    check("post_rst_ready", 64'(wb.req_ready), 64'd1);
    cyc();
    rv = 3'b000; drive();
    cyc();

    // Requester 1 writes r5
    rv = 3'b010; ra[1] = 5'd5; rd[1] = 32'hDEADBEEF; drive();
    cyc();
    check("w5_rw", 64'(rf_rw), 64'd1);
    check("w5_addr", 64'(rf_addr3), 64'd5);
    check("w5_data", 64'(rf_wdata), 64'hDEADBEEF);
    rv = 3'b000; drive();
    cyc();
    check("w5_rw_after", 64'(rf_rw), 64'd0);

    // Hazard on r7 lasts until two edges after its write-back handshake
    pend_set = 1; pend_addr = 5'd7; rd_addr1 = 5'd7; drive();
    cyc();
    pend_set = 0;
    #1;
    check("haz7_set", 64'(hazard1), 64'd1);
    rv = 3'b001; ra[0] = 5'd7; rd[0] = 32'h0000_7777; drive();
    cyc();
    check("haz7_hs", 64'(hazard1), 64'd1);
    rv = 3'b000; drive();
    cyc();
    check("haz7_clr", 64'(hazard1), 64'd0);

    // Set on the clearing edge wins without a dup error; a second set flags it
    pend_set = 1; pend_addr = 5'd7; drive();
    cyc();
    pend_set = 0; rv = 3'b001; drive();
    cyc();
    rv = 3'b000; pend_set = 1; pend_addr = 5'd7; drive();
    cyc();
    check("sc_busy7", 64'(busy_mask[7]), 64'd1);
    check("sc_dup", 64'(dup_err), 64'd0);
    cyc();
    check("dup_set", 64'(dup_err), 64'd1);
    pend_set = 0;

    // Write to x0 is accepted but dropped; pointer moves to requester 2
    rv = 3'b100; ra[2] = 5'd0; rd[2] = 32'h1234_5678; drive();
    #1;
    check("x0_ready", 64'(wb.req_ready), 64'b100);
    cyc();
    check("x0_rw", 64'(rf_rw), 64'd0);
    check("x0_busy", 64'(busy_mask), 64'h80);
    rv = 3'b111; ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd3; drive();
    #1;
    check("x0_ptr", 64'(wb.req_ready), 64'b001);
    cyc();

    // Randomized traffic: requesters hold until granted
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_g == i || !rv[i]) begin
          rv[i] = ($urandom_range(0, 2) != 0);
          ra[i] = 5'($urandom_range(0, 7));
          rd[i] = $urandom;
        end
      end
      pend_set  = ($urandom_range(0, 3) == 0);
      pend_addr = 5'($urandom_range(0, 7));
      rd_addr1  = 5'($urandom_range(0, 7));
      rd_addr2  = 5'($urandom_range(0, 31));
      drive();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
